// File: rtl/mmio_uart_bridge.sv
// UART-to-MMIO command bridge: decodes command bytes from the RX FIFO into single
// read/write strobes on one slot and returns ack, read data or error bytes to the TX FIFO.
module mmio_uart_bridge #(
  parameter int TIMEOUT = 1_000_000,
  parameter int TW      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rd_uart,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic        cs,
  output logic        read,
  output logic        write,
  output logic [4:0]  addr,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, GET_DATA, DO_WRITE, SEND_ACK, DO_READ, SEND_DATA, SEND_ERR
  } state_t;

  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  state_t        state, state_nxt;
  logic [4:0]    addr_q, addr_nxt;
  logic [31:0]   wr_data_q, wr_data_nxt;
  logic [31:0]   shreg, shreg_nxt;
  logic [1:0]    byte_cnt, byte_cnt_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          pop, push;
  logic [7:0]    tx_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      shreg     <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      wr_data_q <= wr_data_nxt;
      shreg     <= shreg_nxt;
      byte_cnt  <= byte_cnt_nxt;
      tmo_cnt   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    wr_data_nxt  = wr_data_q;
    shreg_nxt    = shreg;
    byte_cnt_nxt = byte_cnt;
    tmo_nxt      = tmo_cnt;
    pop          = 1'b0;
    push         = 1'b0;
    tx_byte      = 8'h00;
    case (state)
      IDLE: begin
        if (!rx_empty) begin
          pop = 1'b1;
          if (rx_data[6:5] != 2'b00) begin
            state_nxt = SEND_ERR;
          end else if (rx_data[7]) begin
            addr_nxt     = rx_data[4:0];
            byte_cnt_nxt = '0;
            tmo_nxt      = '0;
            state_nxt    = GET_DATA;
          end else begin
            addr_nxt  = rx_data[4:0];
            state_nxt = DO_READ;
          end
        end
      end
      GET_DATA: begin
        // An expired inter-byte gap aborts before any further byte is consumed.
        if (tmo_cnt == TMO_MAX) begin
          state_nxt = IDLE;
        end else if (!rx_empty) begin
          pop                                 = 1'b1;
          tmo_nxt                             = '0;
          wr_data_nxt[{byte_cnt, 3'b000} +: 8] = rx_data;
          byte_cnt_nxt                        = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_nxt = DO_WRITE;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      DO_WRITE: state_nxt = SEND_ACK;
      DO_READ: begin
        shreg_nxt    = rd_data;
        byte_cnt_nxt = '0;
        state_nxt    = SEND_DATA;
      end
      SEND_ACK: begin
        tx_byte = 8'h4B;
        if (!tx_full) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND_DATA: begin
        tx_byte = shreg[7:0];
        if (!tx_full) begin
          push         = 1'b1;
          shreg_nxt    = {8'h00, shreg[31:8]};
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state_nxt = IDLE;
        end
      end
      SEND_ERR: begin
        tx_byte = 8'h45;
        if (!tx_full) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The pop is masked during reset so no byte is lost while the bridge is held.
  assign rd_uart = pop & ~reset;
  assign wr_uart = push;
  assign tx_data = tx_byte;
  assign cs      = (state == DO_WRITE) || (state == DO_READ);
  assign write   = (state == DO_WRITE);
  assign read    = (state == DO_READ);
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge with modelled RX/TX FIFOs and a scoreboard
// of expected slot strobes and TX bytes.
module tb_mmio_uart_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rd_uart;
  logic [7:0]  tx_data;
  logic        tx_full;
  logic        wr_uart;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_pop = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_strb[$];

  mmio_uart_bridge #(.TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
    .rd_uart(rd_uart), .tx_data(tx_data), .tx_full(tx_full), .wr_uart(wr_uart),
    .cs(cs), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present RX head, sample DUT decisions before the edge, advance.
  task automatic tick();
    logic [39:0] obs;
    rx_empty = (rxq.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rxq[0];
    #1;
    if (rd_uart) begin
      chk("rx_pop_when_empty", {63'd0, rx_empty}, 64'd0);
      last_pop = cyc;
      if (rxq.size() != 0) void'(rxq.pop_front());
    end
    if (wr_uart) begin
      chk("tx_push_when_full", {63'd0, tx_full}, 64'd0);
      if (exp_tx.size() == 0) chk("tx_unexpected", {55'd0, 1'b1, tx_data}, 64'd0);
      else chk("tx_byte", {56'd0, tx_data}, {56'd0, exp_tx.pop_front()});
    end
    if (cs | read | write) begin
      obs = {cs, write, read, addr, write ? wr_data : 32'h0};
      if (exp_strb.size() == 0) chk("strobe_unexpected", {24'd0, obs}, 64'd0);
      else begin
        chk("strobe", {24'd0, obs}, {24'd0, exp_strb.pop_front()});
        chk("strobe_latency", 64'(cyc - last_pop), 64'd1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_tx.size() == 0 && exp_strb.size() == 0 && rxq.size() == 0 && !busy) break;
      tick();
    end
    chk({tag, "_tx_left"}, 64'(exp_tx.size()), 64'd0);
    chk({tag, "_strobe_left"}, 64'(exp_strb.size()), 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic expect_read_data(input logic [4:0] a);
    exp_strb.push_back({1'b1, 1'b0, 1'b1, a, 32'h0});
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hAD);
    exp_tx.push_back(8'hDE);
  endtask

  initial begin
    reset    = 1'b1;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    tx_full  = 1'b0;
    rd_data  = 32'hDEADBEEF;
    tick();
    tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_strobes", {61'd0, cs, read, write}, 64'd0);
    chk("reset_addr", {59'd0, addr}, 64'd0);
    chk("reset_wr_data", {32'd0, wr_data}, 64'd0);
    chk("reset_fifo_ctl", {62'd0, rd_uart, wr_uart}, 64'd0);
    reset = 1'b0;
    tick();

    // Write 0x12345678 to register 3.
    push_rx(8'h83); push_rx(8'h78); push_rx(8'h56); push_rx(8'h34); push_rx(8'h12);
    exp_strb.push_back({1'b1, 1'b1, 1'b0, 5'd3, 32'h12345678});
    exp_tx.push_back(8'h4B);
    drain("write");

    // Read register 5.
    push_rx(8'h05);
    expect_read_data(5'd5);
    drain("read");

    // Reserved bits set: error byte, no strobe.
    push_rx(8'h60);
    exp_tx.push_back(8'h45);
    drain("reserved");

    // Timeout after one data byte, then a normal read.
    push_rx(8'h81); push_rx(8'hAA);
    for (int i = 0; i < 10 && rxq.size() != 0; i++) tick();
    repeat (10) tick();
    chk("timeout_not_early", {63'd0, busy}, 64'd1);
    repeat (14) tick();
    chk("timeout_idle", {63'd0, busy}, 64'd0);
    push_rx(8'h01);
    expect_read_data(5'd1);
    drain("after_timeout");

    // TX backpressure during read data return.
    tx_full = 1'b1;
    push_rx(8'h05);
    expect_read_data(5'd5);
    for (int i = 0; i < 20 && exp_strb.size() != 0; i++) tick();
    repeat (10) tick();
    chk("bp_still_busy", {63'd0, busy}, 64'd1);
    chk("bp_bytes_held", 64'(exp_tx.size()), 64'd4);
    tx_full = 1'b0;
    drain("backpressure");

    // Reset after the second data byte of a write.
    push_rx(8'h82); push_rx(8'h11); push_rx(8'h22);
    for (int i = 0; i < 20 && rxq.size() != 0; i++) tick();
    chk("midwrite_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_strobes", {61'd0, cs, read, write}, 64'd0);
    chk("midreset_addr", {59'd0, addr}, 64'd0);
    chk("midreset_wr_data", {32'd0, wr_data}, 64'd0);
    chk("midreset_fifo_ctl", {62'd0, rd_uart, wr_uart}, 64'd0);
    chk("midreset_tx_data", {56'd0, tx_data}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    push_rx(8'h82); push_rx(8'hA1); push_rx(8'hB2); push_rx(8'hC3); push_rx(8'hD4);
    exp_strb.push_back({1'b1, 1'b1, 1'b0, 5'd2, 32'hD4C3B2A1});
    exp_tx.push_back(8'h4B);
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_uart_bridge.md
Name: mmio_uart_bridge

Overview:
- Command bridge that turns a byte stream from the UART receive FIFO into single-slot MMIO read/write transactions.
- Drives the standard slot interface (cs/read/write/addr/wr_data/rd_data) of one downstream device core, e.g. a GPO slot.
- Returns acknowledge, read data or error bytes to the UART transmit FIFO.
- Lets the host poke slot registers over serial without a CPU.

Parameters:
- TIMEOUT, 1_000_000, idle clk cycles allowed between bytes of one command before abort; must be ≥1.
- TW, 20, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  head byte of RX FIFO (first-word fall-through, valid while rx_empty=0)
- rx_empty  in  1  RX FIFO empty
- rd_uart  out  1  pop RX FIFO head, one-cycle pulse
- tx_data  out  8  byte to push to TX FIFO
- tx_full  in  1  TX FIFO full
- wr_uart  out  1  push tx_data, one-cycle pulse
- cs  out  1  slot chip select
- read  out  1  slot read strobe
- write  out  1  slot write strobe
- addr  out  5  slot register address
- wr_data  out  32  slot write data
- rd_data  in  32  slot read data (combinational from slot)
- busy  out  1  high whenever FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM=IDLE, byte counter=0, timeout counter=0. Asynchronous and immediate: mid-transaction state is discarded, with no ack and no slot strobe afterwards.
- Command byte: bit7=W (1=write, 0=read); bits6:5 reserved, must be 00; bits4:0=addr.
- FIFO handshake: rd_uart=1 only in a cycle where rx_empty=0, consuming rx_data that cycle. wr_uart=1 only where tx_full=0, with tx_data valid that cycle. Never more than one pop and one push per cycle.
- IDLE:
  - On !rx_empty, pop the byte.
  - Reserved bits ≠00 -> SEND_ERR.
  - W=1 -> latch addr, clear byte count -> GET_DATA.
  - W=0 -> latch addr -> DO_READ.
- GET_DATA:
  - Pop 4 bytes, little-endian: byte0 -> wr_data[7:0] … byte3 -> wr_data[31:24].
  - After the 4th pop -> DO_WRITE.
  - Timeout counter clears on each pop and increments otherwise. When it reaches TIMEOUT -> IDLE silently, with no write and no output byte.
- DO_WRITE: exactly one cycle with cs=1, write=1, addr and wr_data stable -> SEND_ACK.
- SEND_ACK: push 0x4B ('K') when !tx_full, then -> IDLE.
- DO_READ: one cycle with cs=1, read=1; capture rd_data into a 32-bit shift register that same cycle -> SEND_DATA.
- SEND_DATA: push 4 bytes LSB first, each waiting on !tx_full (stall indefinitely, no timeout), then -> IDLE.
- SEND_ERR: push 0x45 ('E') when !tx_full, then -> IDLE.
- Strobes: cs/read/write are 0 in every state except DO_WRITE/DO_READ. addr and wr_data hold their last latched value outside strobes.
- Latency, write: 4th data byte popped at cycle N -> write strobe at N+1 -> ack push earliest at N+2.
- Latency, read: command popped at N -> read strobe at N+1 -> first data push earliest at N+2, then one byte per cycle if TX not full.
- RX gating: bytes arriving while in DO_*/SEND_* states stay in the RX FIFO (rd_uart=0) and are handled after return to IDLE.
- Timeout counter saturates at TIMEOUT; no wrap-around.

Test Plan:
- Write: RX bytes 0x83,0x78,0x56,0x34,0x12 -> one cycle cs=1,write=1,addr=3,wr_data=0x12345678; TX receives 0x4B; busy drops after ack.
- Read: rd_data tied to 0xDEADBEEF, RX byte 0x05 -> one cycle cs=1,read=1,addr=5; TX receives 0xEF,0xBE,0xAD,0xDE in order.
- Reserved bits: RX byte 0x60 -> TX receives 0x45; no cs/read/write pulses.
- Timeout: TIMEOUT=16, RX 0x81,0xAA then 20 idle cycles -> return to IDLE, no write, no TX byte. A following 0x01 read completes normally.
- TX backpressure: read command with tx_full held 1 for 10 cycles after the strobe -> wr_uart stays 0 while full; the 4 bytes emerge correctly, none dropped or duplicated.
- Reset mid-write: assert reset after the 2nd data byte -> all outputs 0 immediately. Next full write command 0x82+4 bytes executes with fresh data, no stale bytes.
